// File: rtl/tdc_meas_pkg.sv
// Shared types and defaults for the TDC measurement controller.
package tdc_meas_pkg;

  localparam int unsigned TDC_DATA_WIDTH = 252;
  localparam int unsigned TDC_CNT_W      = $clog2(TDC_DATA_WIDTH + 1);
  localparam int unsigned TDC_DELAY_W    = 4;

  typedef logic [TDC_CNT_W-1:0]   tdc_count_t;
  typedef logic [TDC_DELAY_W-1:0] tdc_delay_t;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StArm,
    StFire,
    StSettle,
    StCapture,
    StDecode,
    StResp
  } tdc_state_e;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tdc_therm_decode.sv
// Thermometer decode: index of the first zero from bit 0, plus a flag for any one above it.
module tdc_therm_decode
  import tdc_meas_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TDC_DATA_WIDTH,
  parameter int unsigned CNT_W      = TDC_CNT_W
) (
  input  logic [DATA_WIDTH-1:0] therm,
  output logic [CNT_W-1:0]      count,
  output logic                  bubble
);

  always_comb begin : decode
    logic found;
    count  = CNT_W'(DATA_WIDTH);
    bubble = 1'b0;
    found  = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (!found && !therm[i]) begin
        count = CNT_W'(i);
        found = 1'b1;
      end else if (found && therm[i]) begin
        bubble = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement controller: fires start/stop edges, captures and decodes the thermometer code.
// Define TDC_ACCUM_EN to run 2**ACC_LOG2 shots per request and sum their counts.
module tdc_meas_ctrl
  import tdc_meas_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = TDC_DATA_WIDTH,
  parameter int unsigned CNT_W         = TDC_CNT_W,
  parameter int unsigned DELAY_W       = TDC_DELAY_W,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned RST_CYCLES    = 2,
  parameter int unsigned ACC_LOG2      = 2,
`ifdef TDC_ACCUM_EN
  localparam int unsigned RSP_W        = CNT_W + ACC_LOG2
`else
  localparam int unsigned RSP_W        = CNT_W
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DELAY_W-1:0]    req_delay,
  output logic                  tdc_a,
  output logic                  tdc_b,
  output logic                  tdc_reset_b,
  input  logic [DATA_WIDTH-1:0] tdc_dout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RSP_W-1:0]      rsp_count,
  output logic                  rsp_bubble
);

  localparam int unsigned CYC_W =
      $clog2(max3(RST_CYCLES, (1 << DELAY_W) - 1, SETTLE_CYCLES) + 1);

  tdc_state_e            state;
  logic [CYC_W-1:0]      cnt;
  logic [DELAY_W-1:0]    delay_q;
  logic [DATA_WIDTH-1:0] cap;
  logic [CNT_W-1:0]      dec_count;
  logic                  dec_bubble;
  logic                  last_shot;

`ifdef TDC_ACCUM_EN
  logic [ACC_LOG2-1:0]   shot;
  assign last_shot = &shot;
`else
  assign last_shot = 1'b1;
`endif

  assign req_ready = (state == StIdle);

  tdc_therm_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_decode (
    .therm  (cap),
    .count  (dec_count),
    .bubble (dec_bubble)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= StIdle;
      cnt         <= '0;
      delay_q     <= '0;
      cap         <= '0;
      tdc_a       <= 1'b0;
      tdc_b       <= 1'b0;
      tdc_reset_b <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_count   <= '0;
      rsp_bubble  <= 1'b0;
`ifdef TDC_ACCUM_EN
      shot        <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            delay_q    <= req_delay;
            cnt        <= CYC_W'(RST_CYCLES - 1);
            rsp_count  <= '0;
            rsp_bubble <= 1'b0;
`ifdef TDC_ACCUM_EN
            shot       <= '0;
`endif
            state      <= StClear;
          end
        end
        StClear: begin
          if (cnt == '0) begin
            tdc_reset_b <= 1'b1;
            state       <= StArm;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StArm: begin
          tdc_a <= 1'b1;
          tdc_b <= (delay_q == '0);
          cnt   <= CYC_W'(delay_q);
          state <= StFire;
        end
        StFire: begin
          // cnt counts down to zero over d+1 cycles; stop must be high in the last one
          if (cnt == '0) begin
            cnt   <= CYC_W'(SETTLE_CYCLES - 1);
            state <= StSettle;
          end else begin
            if (cnt == CYC_W'(1)) tdc_b <= 1'b1;
            cnt <= cnt - 1'b1;
          end
        end
        StSettle: begin
          if (cnt == '0) state <= StCapture;
          else           cnt   <= cnt - 1'b1;
        end
        StCapture: begin
          cap   <= tdc_dout;
          tdc_a <= 1'b0;
          tdc_b <= 1'b0;
          state <= StDecode;
        end
        StDecode: begin
          rsp_count   <= rsp_count + RSP_W'(dec_count);
          rsp_bubble  <= rsp_bubble | dec_bubble;
          tdc_reset_b <= 1'b0;
          if (last_shot) begin
            rsp_valid <= 1'b1;
            state     <= StResp;
          end else begin
`ifdef TDC_ACCUM_EN
            shot      <= shot + 1'b1;
`endif
            cnt       <= CYC_W'(RST_CYCLES - 1);
            state     <= StClear;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Scoreboard bench for tdc_meas_ctrl: random requests, timeline reference model for the TDC pins.
module tb_tdc_meas_ctrl;
  import tdc_meas_pkg::*;

  localparam int DW = 252;
  localparam int R  = 2;
  localparam int S  = 4;
`ifdef TDC_ACCUM_EN
  localparam int SHOTS = 4;
  localparam int RSP_W = 10;
`else
  localparam int SHOTS = 1;
  localparam int RSP_W = 8;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  tdc_delay_t       req_delay;
  logic             tdc_a, tdc_b, tdc_reset_b;
  logic [DW-1:0]    tdc_dout;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [RSP_W-1:0] rsp_count;
  logic             rsp_bubble;

  tdc_meas_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_delay   (req_delay),
    .tdc_a       (tdc_a),
    .tdc_b       (tdc_b),
    .tdc_reset_b (tdc_reset_b),
    .tdc_dout    (tdc_dout),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_count   (rsp_count),
    .rsp_bubble  (rsp_bubble)
  );

  initial forever #5 clock = ~clock;

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  int total = 0;
  int bad   = 0;
  logic [RSP_W:0] sb[$];          // {bubble, count}
  int             pat_n [SHOTS];
  logic [DW-1:0]  pat_m [SHOTS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] mk_pat(input int n, input logic [DW-1:0] m);
    logic [DW-1:0] all1;
    all1 = '1;
    return (all1 >> (DW - n)) | m;
  endfunction

  function automatic logic [DW-1:0] gen_mask(input int n, input bit want);
    logic [DW-1:0] all1;
    all1 = '1;
    return want ? (rand_vec() & (all1 << (n + 1))) : '0;
  endfunction

  // Expected {a, b, reset_b, rsp_valid} k cycles after the accept cycle.
  function automatic logic [3:0] exp_wave(input int k, input int d);
    int len, p;
    len = R + d + S + 4;
    if (k > SHOTS * len) return 4'b0001;
    p = (k - 1) % len;
    if (p < R)              return 4'b0000;
    if (p == R)             return 4'b0010;
    if (p <= R + 1 + d)     return {1'b1, ((p - R - 1) >= d), 2'b10};
    if (p <= R + 2 + d + S) return 4'b1110;
    return 4'b0010;
  endfunction

  // Monitor: tracks each accepted request and checks pins and responses every cycle.
  bit rst_prev = 1'b0;
  bit busy = 1'b0;
  int t0, md, k;
  logic [3:0] w;
  initial forever begin
    @(negedge clock);
    if (rst_prev) begin
      chk("rst_a", tdc_a, 0);
      chk("rst_b", tdc_b, 0);
      chk("rst_reset_b", tdc_reset_b, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_count", rsp_count, 0);
      chk("rst_bubble", rsp_bubble, 0);
      busy = 1'b0;
    end
    if (busy) begin
      k = cyc - t0;
      w = exp_wave(k, md);
      chk("tdc_a", tdc_a, w[3]);
      chk("tdc_b", tdc_b, w[2]);
      chk("tdc_reset_b", tdc_reset_b, w[1]);
      chk("rsp_valid", rsp_valid, w[0]);
      chk("req_ready_busy", req_ready, 0);
      if (w[0] && rsp_valid) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          chk("rsp_count", rsp_count, sb[0][RSP_W-1:0]);
          chk("rsp_bubble", rsp_bubble, sb[0][RSP_W]);
          if (rsp_ready) begin
            void'(sb.pop_front());
            busy = 1'b0;
          end
        end
      end
    end else begin
      chk("idle_a", tdc_a, 0);
      chk("idle_b", tdc_b, 0);
      chk("idle_reset_b", tdc_reset_b, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("req_ready_idle", req_ready, 1);
      if (req_valid && !reset) begin
        busy = 1'b1;
        t0   = cyc;
        md   = int'(req_delay);
      end
    end
    rst_prev = reset;
  end

  // Called in an idle cycle just after a posedge; the request is accepted in this cycle.
  task automatic do_req(input int d, input int stall, input int abort_k);
    int len, sum, p;
    logic bor;
    bit got;
    len = R + d + S + 4;
    sum = 0;
    bor = 1'b0;
    for (int s = 0; s < SHOTS; s++) begin
      sum += pat_n[s];
      bor |= (pat_m[s] != '0);
    end
    req_valid = 1'b1;
    req_delay = tdc_delay_t'(d);
    sb.push_back({bor, RSP_W'(sum)});
    for (int kk = 1; kk <= SHOTS * len; kk++) begin
      @(posedge clock);
      #1;
      req_valid = 1'($urandom_range(0, 1));
      req_delay = tdc_delay_t'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      p = (kk - 1) % len;
      tdc_dout = (p == R + 2 + d + S) ? mk_pat(pat_n[(kk-1)/len], pat_m[(kk-1)/len])
                                      : rand_vec();
      if (kk == abort_k) begin
        reset     = 1'b1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        void'(sb.pop_back());
        return;
      end
    end
    for (int j = 0; j < stall; j++) begin
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      tdc_dout  = rand_vec();
    end
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clock);
      got = rsp_valid;
    end
    chk("rsp_handshake", got, 1);
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic set_all(input int n, input logic [DW-1:0] m);
    for (int s = 0; s < SHOTS; s++) begin
      pat_n[s] = n;
      pat_m[s] = m;
    end
  endtask

  initial begin
    logic [DW-1:0] m;
    int pick;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_delay = '0;
    rsp_ready = 1'b0;
    tdc_dout  = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    set_all(40, '0);   do_req(3, 0, 0);
    set_all(DW, '0);   do_req(0, 0, 0);
    set_all(0, '0);    do_req(0, 1, 0);
    m = '0;
    m[25] = 1'b1;
    set_all(20, m);    do_req(5, 0, 0);
    set_all(100, '0);  do_req(7, 5, 0);
    set_all(60, '0);   do_req(2, 0, R + 2 + 4);
    set_all(33, '0);   do_req(2, 0, 0);
`ifdef TDC_ACCUM_EN
    m = '0;
    m[15] = 1'b1;
    set_all(10, '0);
    pat_m[2] = m;
    do_req(3, 0, 0);
`endif
    for (int i = 0; i < 12; i++) begin
      for (int s = 0; s < SHOTS; s++) begin
        pick = $urandom_range(0, 3);
        pat_n[s] = (pick == 0) ? 0 : (pick == 1) ? DW : $urandom_range(0, DW);
        pat_m[s] = gen_mask(pat_n[s], 1'($urandom_range(0, 1)));
      end
      do_req($urandom_range(0, 15), $urandom_range(0, 3), 0);
    end
    repeat (3) @(posedge clock);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

endmodule
